rr_arbiter_4: RTL and testbench
===============================

Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter. Sits directly upstream of decoder_2to4.
- Outputs a registered 2-bit winner index (sel_out) and a grant-valid (en_out). These drive decoder_2to4 sel_in/en_in, which produces the one-hot grant lines.
- A grant is held until the owner signals done or drops its request. Priority then rotates past the last owner.

Parameters:
- MAX_HOLD, 16, maximum grant length in cycles before forced release. Used only with ARB_TIMEOUT_EN. Legal range 2..255.
- CNT_W, 8, hold-counter width. Must satisfy 2**CNT_W > MAX_HOLD.

Ports:
- clk_in  input  1  single clock; all logic is on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- req_in  input  4  request vector; bit i = requester i.
- done_in  input  1  current owner finished; sampled only in GRANT.
- sel_out  output  2  index of the current owner (registered).
- en_out  output  1  grant valid (registered).
- timeout_out  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (async, rst_in=1):
  - state=IDLE, sel_out=0, en_out=0, timeout_out=0.
  - last_q=3, so requester 0 has top priority after reset.
  - Hold counter = 0.
  - Asserting reset mid-grant drops en_out immediately, without waiting for a clock.
- Pick function (combinational):
  - Search req_in starting at (last_q+1) mod 4 and wrap through 4 positions.
  - Result is idx plus a found flag.
  - With last_q=1 and req_in=4'b1011: search order 2,3,0,1, so idx=3.
- State IDLE:
  - en_out=0.
  - If found: next edge state=GRANT, sel_out=idx, en_out=1, last_q=idx, counter=0.
  - Latency from req_in to en_out is 1 cycle.
  - done_in is ignored.
- State GRANT:
  - sel_out and en_out hold stable. Counter increments each cycle.
  - Release condition: done_in=1, OR req_in[sel_out]=0, OR forced timeout.
  - On release with another requester pending: switch directly to the new winner on the next edge (back-to-back grant, en_out stays 1).
  - Because last_q = current owner, the current owner has the lowest priority in that search. It is re-granted only if no other requester is pending.
  - On release with found=0: state=IDLE, en_out=0 on the next edge. sel_out keeps its last value.
- Simultaneous events:
  - done_in together with the owner's req drop counts as a single release.
  - done_in in the same cycle a new request arrives: the new request is included in the pick.
- Requests are level-sensitive. No request latching or queueing.
- sel_out changes only on an edge where en_out is, or becomes, 1. It never changes while en_out=1 without a release event.
- Arithmetic:
  - All index arithmetic is mod 4 on 2-bit values; wrap 3→0 is natural overflow.
  - Counter saturates at MAX_HOLD-1.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - The counter counts GRANT cycles.
  - When counter==MAX_HOLD-1 and no other release condition is present, force a release on that edge.
  - timeout_out pulses 1 for exactly the cycle after the forced release.
  - Next owner is chosen by the normal pick.
  - A timed-out owner that is still requesting is re-granted only if it is the sole requester. In that case the counter restarts at 0.
- Undefined:
  - No counter logic is built. timeout_out is tied to 0.
  - A grant lasts until done_in or a request drop. MAX_HOLD and CNT_W are unused.

Decomposition:
- Package arb_pkg holds:
  - N_REQ=4, IDX_W=2.
  - State typedef arb_state_t {ST_IDLE, ST_GRANT}.
  - Reset constant LAST_RST=2'd3.
- Sub-module rr_pick4 (combinational): inputs req[3:0] and last[1:0]; outputs idx[1:0] and found.
- The top-level holds the FSM, output registers, last_q and the counter.
- Integration check: rr_arbiter_4 feeding decoder_2to4 must yield a one-hot y_out whenever en_out=1.

Test Plan:
- Reset release with req_in=4'b0000: en_out=0 and sel_out=0 for 10 cycles. Pulse rst_in during this window: outputs stay at reset values.
- req_in=4'b0100 at cycle N: en_out=1 and sel_out=2 at N+1. Pulse done_in with no other requests: en_out=0 one cycle later.
- req_in=4'b1111 held, done_in pulsed every 3 cycles: sel_out sequence 0,1,2,3,0. en_out stays 1 throughout (back-to-back grants).
- Owner 1 granted, req_in changes from 4'b0011 to 4'b0001: next edge sel_out=0, en_out=1.
- Assert rst_in asynchronously mid-grant (sel_out=3, en_out=1): en_out=0 before the next clock edge. After release, req_in=4'b1001 yields sel_out=0.
- With ARB_TIMEOUT_EN and MAX_HOLD=4, req_in=4'b0011 held and no done_in: owner 0 holds 4 cycles, then sel_out=1 and timeout_out=1 for one cycle. Without the macro, owner 0 holds indefinitely.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and constants for the four-requester round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 4;
  localparam int IDX_W = 2;

  typedef enum logic {ST_IDLE, ST_GRANT} arb_state_t;

  // Requester 0 must win first after reset, so the search starts just past 3.
  localparam logic [IDX_W-1:0] LAST_RST = 2'd3;
endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin pick: first requester after `last`, wrapping mod 4.
module rr_pick4
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] last,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  logic [IDX_W-1:0] cand;

  // Walk from farthest to nearest so the nearest hit after `last` is the one kept.
  always_comb begin
    idx   = last;
    found = 1'b0;
    cand  = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      cand = last + IDX_W'(k);
      if (req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with registered owner index and grant valid.
// Optional forced release after MAX_HOLD cycles when ARB_TIMEOUT_EN is defined.
module rr_arbiter_4
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 8
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [N_REQ-1:0] req_in,
  input  logic             done_in,
  output logic [IDX_W-1:0] sel_out,
  output logic             en_out,
  output logic             timeout_out
);

  arb_state_t       state_q, state_d;
  logic [IDX_W-1:0] sel_q, sel_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_found;
  logic             release_w;

  rr_pick4 u_pick (
    .req   (req_in),
    .last  (last_q),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             force_rel;
  logic             timeout_q;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_HOLD - 1);
`else
  logic [CNT_W-1:0] unused_hold_cfg;
  assign unused_hold_cfg = CNT_W'(MAX_HOLD);
`endif

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q   <= ST_IDLE;
      sel_q     <= '0;
      last_q    <= LAST_RST;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= '0;
      timeout_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
`ifdef ARB_TIMEOUT_EN
      cnt_q     <= cnt_d;
      timeout_q <= force_rel;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    release_w = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d     = cnt_q;
    force_rel = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          state_d = ST_GRANT;
          sel_d   = pick_idx;
          last_d  = pick_idx;
`ifdef ARB_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      ST_GRANT: begin
        release_w = done_in || !req_in[sel_q];
`ifdef ARB_TIMEOUT_EN
        force_rel = !release_w && (cnt_q == CNT_LAST);
        release_w = release_w || force_rel;
`endif
        // last_q equals the owner here, so the owner is searched last.
        if (release_w) begin
          if (pick_found) begin
            sel_d  = pick_idx;
            last_d = pick_idx;
`ifdef ARB_TIMEOUT_EN
            cnt_d  = '0;
`endif
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
`ifdef ARB_TIMEOUT_EN
          if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    sel_out = sel_q;
    en_out  = (state_q == ST_GRANT);
`ifdef ARB_TIMEOUT_EN
    timeout_out = timeout_q;
`else
    timeout_out = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios followed by random traffic against a reference model.
module tb_rr_arbiter_4;
  localparam int MH = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b1;
  logic [3:0] req_in = 4'b0000;
  logic       done_in = 1'b0;
  logic [1:0] sel_out;
  logic       en_out;
  logic       timeout_out;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_owner;
  int m_last;
  int m_cnt;
  bit m_en;
  bit m_to;

  rr_arbiter_4 #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .req_in      (req_in),
    .done_in     (done_in),
    .sel_out     (sel_out),
    .en_out      (en_out),
    .timeout_out (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  function automatic void model_reset();
    m_owner = 0;
    m_last  = 3;
    m_cnt   = 0;
    m_en    = 0;
    m_to    = 0;
  endfunction

  function automatic void model_step(input logic [3:0] r, input logic d);
    int  p;
    bit  rel;
    bit  forced;
    forced = 0;
    if (!m_en) begin
      p = pick(r, m_last);
      if (p >= 0) begin
        m_en = 1; m_owner = p; m_last = p; m_cnt = 0;
      end
    end else begin
      rel = d || !r[m_owner];
`ifdef ARB_TIMEOUT_EN
      forced = !rel && (m_cnt == MH - 1);
      rel = rel || forced;
`endif
      if (rel) begin
        p = pick(r, m_last);
        if (p >= 0) begin
          m_owner = p; m_last = p; m_cnt = 0;
        end else begin
          m_en = 0;
        end
      end else if (m_cnt < MH - 1) begin
        m_cnt++;
      end
    end
    m_to = forced;
  endfunction

  task automatic check_model(input string tag);
    check({tag, ".en"}, int'(en_out), int'(m_en));
    check({tag, ".sel"}, int'(sel_out), m_owner);
    check({tag, ".to"}, int'(timeout_out), int'(m_to));
  endtask

  // Drive inputs just after an edge, clock once, compare shortly after the next edge.
  task automatic cycle(input logic [3:0] r, input logic d, input string tag);
    req_in  = r;
    done_in = d;
    @(posedge clk_in);
    model_step(r, d);
    #1;
    check_model(tag);
  endtask

  // Mid-cycle asynchronous reset pulse; outputs must clear before any edge.
  task automatic async_reset(input string tag);
    #3;
    rst_in = 1'b1;
    #1;
    model_reset();
    check_model(tag);
    #2;
    rst_in = 1'b0;
  endtask

  initial begin
    model_reset();
    @(posedge clk_in);
    @(posedge clk_in);
    #1;
    check_model("reset_hold");
    #3;
    rst_in = 1'b0;

    // Idle with no requests, reset pulse in the middle of the window
    for (int i = 0; i < 10; i++) begin
      cycle(4'b0000, 1'b0, "idle");
      if (i == 4) async_reset("idle_rst");
    end

    // Single requester, then done with request dropped
    cycle(4'b0100, 1'b0, "single");
    check("single_sel2", int'(sel_out), 2);
    cycle(4'b0000, 1'b1, "single_done");
    check("single_en_drop", int'(en_out), 0);

    // All requesting, done every third cycle: 0,1,2,3,0 back to back
    async_reset("rr_rst");
    cycle(4'b1111, 1'b0, "rr_start");
    check("rr_first", int'(sel_out), 0);
    for (int g = 0; g < 4; g++) begin
      cycle(4'b1111, 1'b0, "rr_hold");
      cycle(4'b1111, 1'b0, "rr_hold");
      cycle(4'b1111, 1'b1, "rr_done");
      check("rr_seq", int'(sel_out), (g + 1) % 4);
      check("rr_en", int'(en_out), 1);
    end

    // Owner 1 drops its request while 0 still requests
    async_reset("drop_rst");
    cycle(4'b0011, 1'b0, "drop_g0");
    cycle(4'b0011, 1'b1, "drop_g1");
    check("drop_owner1", int'(sel_out), 1);
    cycle(4'b0001, 1'b0, "drop_sw");
    check("drop_sel0", int'(sel_out), 0);
    check("drop_en", int'(en_out), 1);

    // Asynchronous reset mid-grant with owner 3
    async_reset("mid_rst0");
    cycle(4'b1000, 1'b0, "mid_g3");
    check("mid_sel3", int'(sel_out), 3);
    async_reset("mid_rst");
    cycle(4'b1001, 1'b0, "mid_after");
    check("mid_after_sel0", int'(sel_out), 0);

    // Two requesters held without done: timeout behaviour depends on build
    async_reset("to_rst");
    for (int i = 0; i < 5; i++) cycle(4'b0011, 1'b0, "to_hold");
`ifdef ARB_TIMEOUT_EN
    check("to_sel1", int'(sel_out), 1);
    check("to_pulse", int'(timeout_out), 1);
`else
    check("to_sel0", int'(sel_out), 0);
    check("to_none", int'(timeout_out), 0);
`endif
    cycle(4'b0011, 1'b0, "to_after");
    check("to_pulse_end", int'(timeout_out), 0);
    for (int i = 0; i < 6; i++) cycle(4'b0011, 1'b0, "to_more");

    // Random traffic
    async_reset("rnd_rst");
    for (int i = 0; i < 500; i++) begin
      logic [3:0] r;
      logic d;
      r = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) r = 4'b0000;
      d = ($urandom_range(0, 4) == 0);
      cycle(r, d, "rnd");
      if ($urandom_range(0, 99) == 0) async_reset("rnd_async");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
